// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed BCD counter: nibble/segment widths
// and the 7-segment code table, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int NIB_W = 4;
   localparam int SEG_W = 7;
   localparam logic [NIB_W-1:0] BCD_MAX = 4'd9;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
   localparam logic [SEG_W-1:0] SEG_ZERO  = 7'h3F;

   localparam logic [SEG_W-1:0] SEG_LUT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   function automatic logic [SEG_W-1:0] seg_decode(input logic [NIB_W-1:0] d);
      logic [SEG_W-1:0] s;
      s = SEG_BLANK;
      if (d <= BCD_MAX) s = SEG_LUT[int'(d)];
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit with load, increment and decrement; carry/borrow
// report that this digit rolls over on the current inc/dec.
module bcd_digit
   import seg7_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [NIB_W-1:0] ld_val,
   output logic [NIB_W-1:0] value,
   output logic             carry,
   output logic             borrow
);

   logic [NIB_W-1:0] value_q;
   logic [NIB_W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = (ld_val > BCD_MAX) ? BCD_MAX : ld_val;
      end else if (inc) begin
         value_d = (value_q == BCD_MAX) ? '0 : value_q + 4'd1;
      end else if (dec) begin
         value_d = (value_q == '0) ? BCD_MAX : value_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) value_q <= '0;
      else       value_q <= value_d;
   end

   assign value  = value_q;
   assign carry  = inc & ~load & (value_q == BCD_MAX);
   assign borrow = dec & ~load & (value_q == '0);

endmodule

// File: rtl/mux_seg7_counter.sv
// Up/down BCD counter with prescaled count tick and a time-multiplexed
// 7-segment display scan.
module mux_seg7_counter
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 1000,
   parameter int SCAN_DIV   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        up_dn,
   input  logic                        load,
   input  logic [NUM_DIGITS*NIB_W-1:0] load_val,
   output logic [NUM_DIGITS*NIB_W-1:0] count,
   output logic                        wrap,
   output logic [SEG_W-1:0]            segments,
   output logic [NUM_DIGITS-1:0]       digit_sel
);

   localparam int CW = NUM_DIGITS * NIB_W;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]         pre_q, pre_d;
   logic [SW-1:0]         scan_q, scan_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  wrap_q, wrap_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic [CW-1:0]         cnt;
   logic                  tick;

   // A load overrides any coincident tick so the loaded value is not stepped.
   assign tick = en & ~load & (pre_q == PRE_MAX);

   always_comb begin
      pre_d = pre_q;
      if (load)    pre_d = '0;
      else if (en) pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      logic inc_w, dec_w, cy_w, bw_w;
      if (i == 0) begin : g_lsd
         assign inc_w = tick & up_dn;
         assign dec_w = tick & ~up_dn;
      end else begin : g_chain
         assign inc_w = g_dig[i-1].cy_w;
         assign dec_w = g_dig[i-1].bw_w;
      end
      bcd_digit u_digit (
         .clk    (clk),
         .reset  (reset),
         .inc    (inc_w),
         .dec    (dec_w),
         .load   (load),
         .ld_val (load_val[i*NIB_W +: NIB_W]),
         .value  (cnt[i*NIB_W +: NIB_W]),
         .carry  (cy_w),
         .borrow (bw_w)
      );
   end

   assign wrap_d = g_dig[NUM_DIGITS-1].cy_w | g_dig[NUM_DIGITS-1].bw_w;

   always_comb begin
      scan_d = scan_q + SW'(1);
      idx_d  = idx_q;
      if (scan_q == SCAN_MAX) begin
         scan_d = '0;
         idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end
   end

   // Select and pattern are captured together so they never disagree.
   always_comb begin
      sel_d = NUM_DIGITS'(1) << idx_q;
      seg_d = seg_decode(cnt[int'(idx_q)*NIB_W +: NIB_W]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q  <= '0;
         scan_q <= '0;
         idx_q  <= '0;
         wrap_q <= 1'b0;
         sel_q  <= NUM_DIGITS'(1);
         seg_q  <= SEG_ZERO;
      end else begin
         pre_q  <= pre_d;
         scan_q <= scan_d;
         idx_q  <= idx_d;
         wrap_q <= wrap_d;
         sel_q  <= sel_d;
         seg_q  <= seg_d;
      end
   end

   assign count     = cnt;
   assign wrap      = wrap_q;
   assign segments  = seg_q;
   assign digit_sel = sel_q;

endmodule
